// File: rtl/trojan_scan_pkg.sv
// ---------------------------------------------------------------------------
// trojan_scan_pkg : shared types and sizes for the trojan scan controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package trojan_scan_pkg;

   localparam int VEC_W   = 5;
   localparam int NUM_VEC = 32;
   localparam int CNT_W   = 6;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_APPLY   = 3'd1,
      S_SETTLE  = 3'd2,
      S_COMPARE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/trojan_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// trojan_scan_ctrl_if : control, stimulus and result bundle of the scan controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface trojan_scan_ctrl_if;
   import trojan_scan_pkg::*;

   logic             start;
   logic             abort;
   logic [VEC_W-1:0] dut_in;
   logic             dut_y;
   logic             gold_y;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] mismatch_cnt;
   logic             first_fail_valid;
   logic [VEC_W-1:0] first_fail_vec;

   modport master (
      output start, abort, dut_y, gold_y,
      input  dut_in, busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec
   );

   modport slave (
      input  start, abort, dut_y, gold_y,
      output dut_in, busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec
   );

endinterface

`default_nettype wire

// File: rtl/trojan_scan_ctrl.sv
// ---------------------------------------------------------------------------
// trojan_scan_ctrl : applies all 32 input vectors to a DUT and its golden copy,
// counting output mismatches. Option TROJAN_SCAN_STOP_ON_FAIL_EN ends at first mismatch.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trojan_scan_ctrl
   import trojan_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  wire logic         clk,
   input  wire logic         rst,
   trojan_scan_ctrl_if.slave bus
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_VEC    = CNT_W'(NUM_VEC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(NUM_VEC);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] vec_idx;
   logic [3:0]       settle_cnt;
   logic             done_q;
   logic [CNT_W-1:0] mis_cnt;
   logic             ff_valid;
   logic [VEC_W-1:0] ff_vec;

   logic start_ok;
   logic mismatch;
   logic stop_hit;
   logic busy;
   logic do_compare;
   logic count_mis;

   assign start_ok = (state == S_IDLE) && bus.start && !bus.abort;
   assign mismatch = (bus.dut_y != bus.gold_y);

`ifdef TROJAN_SCAN_STOP_ON_FAIL_EN
   assign stop_hit = mismatch;
`else
   assign stop_hit = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state logic; abort pre-empts every active state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start_ok) state_nxt = S_APPLY;
         S_APPLY:   state_nxt = bus.abort ? S_IDLE : S_SETTLE;
         S_SETTLE: begin
            if (bus.abort)                      state_nxt = S_IDLE;
            else if (settle_cnt == SETTLE_LAST) state_nxt = S_COMPARE;
         end
         S_COMPARE: begin
            if (bus.abort)                           state_nxt = S_IDLE;
            else if (stop_hit || vec_idx == LAST_VEC) state_nxt = S_DONE;
            else                                     state_nxt = S_APPLY;
         end
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // output / strobe decode
   always_comb begin
      busy       = 1'b0;
      do_compare = 1'b0;
      case (state)
         S_APPLY, S_SETTLE: busy = 1'b1;
         S_COMPARE: begin
            busy       = 1'b1;
            do_compare = !bus.abort;
         end
         default: ;
      endcase
   end

   assign count_mis = do_compare && mismatch;

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_idx    <= '0;
         settle_cnt <= '0;
         done_q     <= 1'b0;
         mis_cnt    <= '0;
         ff_valid   <= 1'b0;
         ff_vec     <= '0;
      end else if (start_ok) begin
         vec_idx    <= '0;
         settle_cnt <= '0;
         done_q     <= 1'b0;
         mis_cnt    <= '0;
         ff_valid   <= 1'b0;
         ff_vec     <= '0;
      end else begin
         if (state == S_APPLY)  settle_cnt <= '0;
         if (state == S_SETTLE) settle_cnt <= settle_cnt + 4'd1;
         if (count_mis) begin
            if (mis_cnt != CNT_MAX) mis_cnt <= mis_cnt + CNT_W'(1);
            if (!ff_valid) begin
               ff_valid <= 1'b1;
               ff_vec   <= vec_idx[VEC_W-1:0];
            end
         end
         if (do_compare && state_nxt == S_APPLY) vec_idx <= vec_idx + CNT_W'(1);
         if (state_nxt == S_DONE)                done_q  <= 1'b1;
      end
   end

   // the vector index doubles as the stimulus pattern
   assign bus.dut_in           = vec_idx[VEC_W-1:0];
   assign bus.busy             = busy;
   assign bus.done             = done_q;
   assign bus.pass             = done_q && (mis_cnt == '0);
   assign bus.mismatch_cnt     = mis_cnt;
   assign bus.first_fail_valid = ff_valid;
   assign bus.first_fail_vec   = ff_vec;

endmodule

`default_nettype wire

// File: tb/tb_trojan_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trojan_scan_ctrl : directed vector-table bench for trojan_scan_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trojan_scan_ctrl;
   import trojan_scan_pkg::*;

   localparam int SETTLE   = 2;
   localparam int PER_VEC  = SETTLE + 2;
   localparam int SCAN_CYC = NUM_VEC * PER_VEC;

   logic clk = 1'b0;
   logic rst;
   int   mode;
   logic tj;
   int   vectors = 0;
   int   fails   = 0;

   always #5 clk = ~clk;

   trojan_scan_ctrl_if bus ();

   trojan_scan_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // golden netlist is input parity; the trojan flips it on a mode-dependent trigger
   always_comb begin
      tj = 1'b0;
      case (mode)
         1: tj = bus.dut_in[1] & bus.dut_in[0];
         2: tj = &bus.dut_in[4:2];
         3: tj = bus.dut_in[4];
         4: tj = 1'b1;
         5: tj = (bus.dut_in == 5'd31);
         default: tj = 1'b0;
      endcase
   end

   assign bus.gold_y = ^bus.dut_in;
   assign bus.dut_y  = bus.gold_y ^ tj;

   typedef struct {
      int         mode;
      int         cnt;
      logic       ffv;
      logic [4:0] ffvec;
      logic       pass;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
   endtask

   // counts busy cycles until busy drops; 'already' = cycles of this scan before now
   task automatic finish_scan(input int already, output int total);
      total = already;
      while (bus.busy === 1'b1 && total < 2000) begin
         total++;
         @(negedge clk);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_dut_in"}, 32'(bus.dut_in), 0);
      chk({tag, "_busy"},   32'(bus.busy), 0);
      chk({tag, "_done"},   32'(bus.done), 0);
      chk({tag, "_pass"},   32'(bus.pass), 0);
      chk({tag, "_cnt"},    32'(bus.mismatch_cnt), 0);
      chk({tag, "_ffv"},    32'(bus.first_fail_valid), 0);
      chk({tag, "_ffvec"},  32'(bus.first_fail_vec), 0);
   endtask

   initial begin
      int t;
      int exp_cyc;
      int exp_cnt;

      tbl[0] = '{mode: 0, cnt: 0,  ffv: 1'b0, ffvec: 5'b00000, pass: 1'b1};
      tbl[1] = '{mode: 1, cnt: 8,  ffv: 1'b1, ffvec: 5'b00011, pass: 1'b0};
      tbl[2] = '{mode: 2, cnt: 4,  ffv: 1'b1, ffvec: 5'b11100, pass: 1'b0};
      tbl[3] = '{mode: 3, cnt: 16, ffv: 1'b1, ffvec: 5'b10000, pass: 1'b0};
      tbl[4] = '{mode: 4, cnt: 32, ffv: 1'b1, ffvec: 5'b00000, pass: 1'b0};
      tbl[5] = '{mode: 5, cnt: 1,  ffv: 1'b1, ffvec: 5'b11111, pass: 1'b0};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      mode      = 0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;

      // stimulus stepping: vector 0 in cycle 1, vector 1 in cycle 1+PER_VEC
      pulse_start();
      chk("v0_dut_in", 32'(bus.dut_in), 0);
      chk("v0_busy",   32'(bus.busy), 1);
      repeat (PER_VEC) @(negedge clk);
      chk("v1_dut_in", 32'(bus.dut_in), 1);
      finish_scan(PER_VEC, t);
      chk("first_scan_cycles", 32'(t), 32'(SCAN_CYC));

      for (int i = 0; i < 6; i++) begin
         mode = tbl[i].mode;
`ifdef TROJAN_SCAN_STOP_ON_FAIL_EN
         exp_cnt = (tbl[i].cnt == 0) ? 0 : 1;
         exp_cyc = (tbl[i].cnt == 0) ? SCAN_CYC : (int'(tbl[i].ffvec) + 1) * PER_VEC;
`else
         exp_cnt = tbl[i].cnt;
         exp_cyc = SCAN_CYC;
`endif
         pulse_start();
         finish_scan(0, t);
         chk($sformatf("t%0d_cycles", i), 32'(t), 32'(exp_cyc));
         chk($sformatf("t%0d_done", i),   32'(bus.done), 1);
         chk($sformatf("t%0d_pass", i),   32'(bus.pass), 32'(tbl[i].pass));
         chk($sformatf("t%0d_cnt", i),    32'(bus.mismatch_cnt), 32'(exp_cnt));
         chk($sformatf("t%0d_ffv", i),    32'(bus.first_fail_valid), 32'(tbl[i].ffv));
         chk($sformatf("t%0d_ffvec", i),  32'(bus.first_fail_vec), 32'(tbl[i].ffvec));
      end

      // start and abort together in IDLE: abort wins, results from last scan kept
      @(negedge clk);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("sa_busy", 32'(bus.busy), 0);
      chk("sa_done", 32'(bus.done), 1);
      chk("sa_cnt",  32'(bus.mismatch_cnt), 1);

      // abort in the COMPARE of vector 3: that mismatch is not counted
      mode = 1;
      pulse_start();
      repeat (4 * PER_VEC - 1) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk) bus.abort = 1'b0;
      chk("abc_busy", 32'(bus.busy), 0);
      chk("abc_done", 32'(bus.done), 0);
      chk("abc_cnt",  32'(bus.mismatch_cnt), 0);
      chk("abc_ffv",  32'(bus.first_fail_valid), 0);

      // abort during SETTLE of vector 10 keeps partial results
      pulse_start();
      repeat (10 * PER_VEC + 1) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk) bus.abort = 1'b0;
      chk("ab10_busy",  32'(bus.busy), 0);
      chk("ab10_done",  32'(bus.done), 0);
      chk("ab10_pass",  32'(bus.pass), 0);
      chk("ab10_cnt",   32'(bus.mismatch_cnt), 2);
      chk("ab10_ffvec", 32'(bus.first_fail_vec), 3);

      mode = 0;
      pulse_start();
      finish_scan(0, t);
      chk("clean_cycles", 32'(t), 32'(SCAN_CYC));
      chk("clean_pass",   32'(bus.pass), 1);
      chk("clean_cnt",    32'(bus.mismatch_cnt), 0);
      chk("clean_ffv",    32'(bus.first_fail_valid), 0);

      // start re-pulsed at cycle 50 is ignored
      pulse_start();
      repeat (49) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      finish_scan(50, t);
      chk("repulse_cycles", 32'(t), 32'(SCAN_CYC));
      chk("repulse_done",   32'(bus.done), 1);

      // reset during SETTLE of vector 20
      mode = 3;
      pulse_start();
      repeat (20 * PER_VEC + 1) @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset("midrst");
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 32'(bus.busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

`default_nettype wire
